// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the ID-stage hazard / forwarding controller.
package hazard_ctrl_pkg;

  // Default register-specifier width (32 architectural registers).
  localparam int REG_ADDR_W_DEFAULT = 5;

  // EX-stage operand mux selects.
  localparam logic [1:0] FWD_NONE = 2'b00;  // register file / ID/EX value
  localparam logic [1:0] FWD_WB   = 2'b01;  // MEM/WB write-back value
  localparam logic [1:0] FWD_MEM  = 2'b10;  // EX/MEM ALU result

  // Stall FSM encoding.
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Number of stall cycles a hazard needs (0, 1 or 2).
  typedef logic [1:0] need_t;
  localparam need_t NEED_NONE = 2'd0;
  localparam need_t NEED_ONE  = 2'd1;
  localparam need_t NEED_TWO  = 2'd2;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Three-way priority forwarding select for one EX-stage operand.
// EX/MEM beats MEM/WB because it carries the younger result.
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            sel,
  output logic                  mem_hit
);

  logic wb_hit;

  // Register 0 is hard-wired zero, so a write to it never forwards.
  always_comb begin
    mem_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == src);
    wb_hit  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == src);
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
    else             sel = FWD_NONE;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller for the 5-stage MIPS pipeline: forwarding
// selects for the EX ALU muxes and the ID branch comparator, stall /
// bubble / flush controls, and saturating stall and flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_is_branch,
  input  logic                  id_branch_taken,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_regwrite,
  input  logic                  mem_memread,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            fwd_ex_a,
  output logic [1:0]            fwd_ex_b,
  output logic                  fwd_id_a,
  output logic                  fwd_id_b,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic                  ifid_flush,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  logic [1:0] sel_a, sel_b;
  logic       unused_hit_a, unused_hit_b;
  logic       mem_fwd_ok;
  logic       ex_match, mem_match;
  need_t      need;
  logic [0:0] state, state_nxt;
  logic       stall, flush;

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .src          (ex_rs),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .sel          (sel_a),
    .mem_hit      (unused_hit_a)
  );

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .src          (ex_rt),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .sel          (sel_b),
    .mem_hit      (unused_hit_b)
  );

  // Branch-comparator forwarding: only the EX/MEM ALU result is usable in ID
  // (a load's data is not ready yet, and WB is covered by write-before-read).
  always_comb begin
    mem_fwd_ok = mem_regwrite && !mem_memread && (mem_rd != '0);
    fwd_id_a   = !reset && mem_fwd_ok && (mem_rd == id_rs);
    fwd_id_b   = !reset && mem_fwd_ok && id_uses_rt && (mem_rd == id_rt);
    fwd_ex_a   = reset ? FWD_NONE : sel_a;
    fwd_ex_b   = reset ? FWD_NONE : sel_b;
  end

  // Does the ID instruction read the destination of an older instruction?
  always_comb begin
    ex_match  = (ex_rd != '0) &&
                ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    mem_match = (mem_rd != '0) &&
                ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));
  end

  // Stall cycles required: a load feeding a branch needs two (data only
  // reaches WB), anything else forwarding cannot cover needs one.
  always_comb begin
    need = NEED_NONE;
    if (ex_memread && ex_match && id_is_branch)
      need = NEED_TWO;
    else if ((ex_memread && ex_match) ||
             (id_is_branch && ex_regwrite && ex_match) ||
             (id_is_branch && mem_memread && mem_match))
      need = NEED_ONE;
  end

  // Mealy stall: asserted the cycle the hazard is seen, plus one HOLD cycle
  // for the two-cycle case during which hazard inputs are ignored.
  always_comb begin
    stall     = !reset && ((state == ST_HOLD) || (need != NEED_NONE));
    state_nxt = ((state == ST_RUN) && (need == NEED_TWO)) ? ST_HOLD : ST_RUN;
  end

  // Pipeline register controls; a stalled branch must not flush yet.
  always_comb begin
    flush       = !reset && id_is_branch && id_branch_taken && !stall;
    pc_write    = !stall;
    ifid_write  = !stall;
    idex_bubble = stall;
    ifid_flush  = flush;
  end

  // Stall FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
      if (flush && !(&flush_count)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int RW   = 5;
  localparam int CW   = 4;   // narrow counters so saturation is reachable
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [RW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic          id_uses_rt, id_is_branch, id_branch_taken;
  logic          ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite;
  logic [1:0]    fwd_ex_a, fwd_ex_b;
  logic          fwd_id_a, fwd_id_b, pc_write, ifid_write, idex_bubble, ifid_flush;
  logic [CW-1:0] stall_count, flush_count;

  int checks = 0;
  int fails  = 0;

  // Reference model state: "a second stall cycle is owed", and counts.
  bit m_hold;
  int m_sc, m_fc;

  hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .fwd_ex_a(fwd_ex_a), .fwd_ex_b(fwd_ex_b),
    .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit reads(input logic [RW-1:0] r);
    return (r != 0) && ((r == id_rs) || (id_uses_rt && (r == id_rt)));
  endfunction

  function automatic int need();
    int n = 0;
    if (id_is_branch && mem_memread && reads(mem_rd)) n = 1;
    if (id_is_branch && ex_regwrite && !ex_memread && reads(ex_rd)) n = 1;
    if (ex_memread && reads(ex_rd)) n = id_is_branch ? 2 : 1;
    return n;
  endfunction

  function automatic logic [1:0] exsel(input logic [RW-1:0] s);
    if (mem_regwrite && mem_rd != 0 && mem_rd == s) return 2'd2;
    if (wb_regwrite && wb_rd != 0 && wb_rd == s)    return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit exp_stall();
    return !reset && (m_hold || need() > 0);
  endfunction

  function automatic bit exp_flush();
    return !reset && id_is_branch && id_branch_taken && !exp_stall();
  endfunction

  // Advance model across the coming rising edge, then step past it.
  task automatic adv();
    bit st, fl;
    int n;
    if (!reset) begin
      n  = need();
      st = exp_stall();
      fl = exp_flush();
      if (st && m_sc < MAXC) m_sc++;
      if (fl && m_fc < MAXC) m_fc++;
      m_hold = !m_hold && (n == 2);
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_in();
    {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rt, id_is_branch, id_branch_taken} = '0;
    {ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite} = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_hold = 0; m_sc = 0; m_fc = 0;
    clear_in();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_in();
    @(negedge clk);
    reset = 1'b1;
    m_hold = 0; m_sc = 0; m_fc = 0;
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_rs = 5; id_is_branch = 1;
    id_branch_taken = 1; mem_regwrite = 1; mem_rd = 5; ex_rs = 5; ex_rt = 5;
    #2;
    checks++;
    if ({pc_write, ifid_write, idex_bubble, ifid_flush} !== 4'b1100) begin
      fails++; $display("FAIL reset_ctrl got %b want 1100", {pc_write, ifid_write, idex_bubble, ifid_flush});
    end
    checks++;
    if ({fwd_ex_a, fwd_ex_b, fwd_id_a, fwd_id_b} !== 6'b0) begin
      fails++; $display("FAIL reset_fwd got %b want 000000", {fwd_ex_a, fwd_ex_b, fwd_id_a, fwd_id_b});
    end
    checks++;
    if (stall_count !== 0 || flush_count !== 0) begin
      fails++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_count, flush_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    clear_in();
  endtask

  task automatic test_fwd();
    do_reset();
    mem_regwrite = 1; mem_rd = 8; wb_regwrite = 1; wb_rd = 8; ex_rs = 8; ex_rt = 8;
    @(negedge clk);
    checks++;
    if (fwd_ex_a !== 2'b10 || fwd_ex_b !== 2'b10) begin
      fails++; $display("FAIL fwd_mem_prio got %b/%b want 10/10", fwd_ex_a, fwd_ex_b);
    end
    adv();
    mem_rd = 9; ex_rt = 9;
    @(negedge clk);
    checks++;
    if (fwd_ex_a !== 2'b01 || fwd_ex_b !== 2'b10) begin
      fails++; $display("FAIL fwd_wb got %b/%b want 01/10", fwd_ex_a, fwd_ex_b);
    end
    adv();
    id_rs = 9; id_rt = 9; id_uses_rt = 0;
    @(negedge clk);
    checks++;
    if (fwd_id_a !== 1'b1 || fwd_id_b !== 1'b0) begin
      fails++; $display("FAIL fwd_id_uses_rt got %b%b want 10", fwd_id_a, fwd_id_b);
    end
    adv();
    id_uses_rt = 1; mem_memread = 1;
    @(negedge clk);
    checks++;
    if (fwd_id_a !== 1'b0 || fwd_id_b !== 1'b0) begin
      fails++; $display("FAIL fwd_id_load got %b%b want 00", fwd_id_a, fwd_id_b);
    end
    adv();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_rs = 5;
    @(negedge clk);
    checks++;
    if ({pc_write, ifid_write, idex_bubble} !== 3'b001) begin
      fails++; $display("FAIL load_use_stall got %b want 001", {pc_write, ifid_write, idex_bubble});
    end
    adv();
    ex_memread = 0; ex_regwrite = 0; ex_rd = 0;
    mem_memread = 1; mem_regwrite = 1; mem_rd = 5;
    @(negedge clk);
    checks++;
    if (pc_write !== 1'b1 || stall_count !== 1) begin
      fails++; $display("FAIL load_use_release got pc_write=%b cnt=%0d want 1/1", pc_write, stall_count);
    end
    adv();
  endtask

  task automatic test_load_branch();
    do_reset();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_rs = 5;
    id_is_branch = 1; id_branch_taken = 1;
    @(negedge clk);
    checks++;
    if (pc_write !== 1'b0 || ifid_flush !== 1'b0) begin
      fails++; $display("FAIL ld_br_run got pc_write=%b flush=%b want 0/0", pc_write, ifid_flush);
    end
    adv();
    ex_memread = 0; ex_regwrite = 0; ex_rd = 0;
    mem_memread = 1; mem_regwrite = 1; mem_rd = 5;
    @(negedge clk);
    checks++;
    if (idex_bubble !== 1'b1 || ifid_flush !== 1'b0) begin
      fails++; $display("FAIL ld_br_hold got bubble=%b flush=%b want 1/0", idex_bubble, ifid_flush);
    end
    adv();
    mem_memread = 0; mem_regwrite = 0; mem_rd = 0;
    wb_regwrite = 1; wb_rd = 5;
    @(negedge clk);
    checks++;
    if ({fwd_id_a, pc_write, ifid_flush} !== 3'b011) begin
      fails++; $display("FAIL ld_br_resolve got %b want 011", {fwd_id_a, pc_write, ifid_flush});
    end
    adv();
    clear_in();
    @(negedge clk);
    checks++;
    if (stall_count !== 2 || flush_count !== 1) begin
      fails++; $display("FAIL ld_br_counts got %0d/%0d want 2/1", stall_count, flush_count);
    end
    adv();
  endtask

  task automatic test_alu_branch();
    do_reset();
    ex_regwrite = 1; ex_rd = 3; id_rs = 1; id_rt = 3; id_uses_rt = 1; id_is_branch = 1;
    @(negedge clk);
    checks++;
    if (pc_write !== 1'b0 || fwd_id_b !== 1'b0) begin
      fails++; $display("FAIL alu_br_stall got pc_write=%b fwd_id_b=%b want 0/0", pc_write, fwd_id_b);
    end
    adv();
    ex_regwrite = 0; ex_rd = 0; mem_regwrite = 1; mem_rd = 3;
    @(negedge clk);
    checks++;
    if (fwd_id_b !== 1'b1 || pc_write !== 1'b1) begin
      fails++; $display("FAIL alu_br_fwd got fwd_id_b=%b pc_write=%b want 1/1", fwd_id_b, pc_write);
    end
    adv();
  endtask

  task automatic test_taken_branch();
    do_reset();
    id_is_branch = 1; id_branch_taken = 1; id_rs = 6;
    @(negedge clk);
    checks++;
    if (ifid_flush !== 1'b1) begin
      fails++; $display("FAIL taken_flush got %b want 1", ifid_flush);
    end
    adv();
    @(negedge clk);
    checks++;
    if (flush_count !== 1) begin
      fails++; $display("FAIL taken_count got %0d want 1", flush_count);
    end
    adv();
    ex_memread = 1; ex_rd = 6;
    @(negedge clk);
    checks++;
    if (ifid_flush !== 1'b0 || pc_write !== 1'b0) begin
      fails++; $display("FAIL taken_stalled got flush=%b pc_write=%b want 0/0", ifid_flush, pc_write);
    end
    adv();
    ex_memread = 0; ex_rd = 0;
    @(negedge clk);
    checks++;
    if (ifid_flush !== 1'b0 || flush_count !== 2) begin
      fails++; $display("FAIL taken_hold got flush=%b cnt=%0d want 0/2", ifid_flush, flush_count);
    end
    adv();
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    ex_memread = 1; ex_rd = 4; id_rs = 4; id_is_branch = 1;
    @(negedge clk);
    adv();
    clear_in();
    @(negedge clk);
    checks++;
    if (pc_write !== 1'b0) begin
      fails++; $display("FAIL hold_benign got pc_write=%b want 0", pc_write);
    end
    #1 reset = 1'b1;
    m_hold = 0; m_sc = 0; m_fc = 0;
    #1;
    checks++;
    if (pc_write !== 1'b1 || stall_count !== 0) begin
      fails++; $display("FAIL hold_reset got pc_write=%b cnt=%0d want 1/0", pc_write, stall_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin
      fails++; $display("FAIL hold_residual got pc_write=%b bubble=%b want 1/0", pc_write, idex_bubble);
    end
    adv();
  endtask

  task automatic test_zero_reg();
    do_reset();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 0; id_rs = 0;
    mem_regwrite = 1; mem_rd = 0; ex_rs = 0;
    @(negedge clk);
    checks++;
    if ({pc_write, fwd_ex_a, fwd_id_a} !== 4'b1000) begin
      fails++; $display("FAIL zero_reg got %b want 1000", {pc_write, fwd_ex_a, fwd_id_a});
    end
    adv();
    ex_memread = 0; id_is_branch = 1;
    @(negedge clk);
    checks++;
    if (pc_write !== 1'b1) begin
      fails++; $display("FAIL zero_reg_branch got pc_write=%b want 1", pc_write);
    end
    adv();
  endtask

  task automatic test_saturation();
    do_reset();
    ex_memread = 1; ex_rd = 7; id_rs = 7;
    for (int i = 0; i < MAXC + 5; i++) adv();
    clear_in();
    id_is_branch = 1; id_branch_taken = 1;
    for (int i = 0; i < MAXC + 5; i++) adv();
    @(negedge clk);
    checks++;
    if (stall_count !== CW'(MAXC) || flush_count !== CW'(MAXC)) begin
      fails++; $display("FAIL saturate got %0d/%0d want %0d/%0d", stall_count, flush_count, MAXC, MAXC);
    end
    adv();
  endtask

  task automatic test_random();
    bit st, fl;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      if (reset) begin m_hold = 0; m_sc = 0; m_fc = 0; end
      id_rs = RW'($urandom_range(0, 3)); id_rt = RW'($urandom_range(0, 3));
      ex_rs = RW'($urandom_range(0, 3)); ex_rt = RW'($urandom_range(0, 3));
      ex_rd = RW'($urandom_range(0, 3)); mem_rd = RW'($urandom_range(0, 3));
      wb_rd = RW'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom); id_is_branch = 1'($urandom);
      id_branch_taken = 1'($urandom);
      ex_regwrite = 1'($urandom); ex_memread = 1'($urandom);
      mem_regwrite = 1'($urandom); mem_memread = 1'($urandom);
      wb_regwrite = 1'($urandom);
      @(negedge clk);
      st = exp_stall();
      fl = exp_flush();
      checks++;
      if ({pc_write, ifid_write, idex_bubble, ifid_flush} !== {!st, !st, st, fl}) begin
        fails++; $display("FAIL rand_ctrl[%0d] got %b want %b", i,
          {pc_write, ifid_write, idex_bubble, ifid_flush}, {!st, !st, st, fl});
      end
      checks++;
      if (fwd_ex_a !== (reset ? 2'd0 : exsel(ex_rs)) || fwd_ex_b !== (reset ? 2'd0 : exsel(ex_rt))) begin
        fails++; $display("FAIL rand_fwd_ex[%0d] got %b/%b", i, fwd_ex_a, fwd_ex_b);
      end
      checks++;
      if (fwd_id_a !== (!reset && mem_regwrite && !mem_memread && mem_rd != 0 && mem_rd == id_rs) ||
          fwd_id_b !== (!reset && mem_regwrite && !mem_memread && mem_rd != 0 && id_uses_rt && mem_rd == id_rt)) begin
        fails++; $display("FAIL rand_fwd_id[%0d] got %b%b", i, fwd_id_a, fwd_id_b);
      end
      checks++;
      if (int'(stall_count) != m_sc || int'(flush_count) != m_fc) begin
        fails++; $display("FAIL rand_cnt[%0d] got %0d/%0d want %0d/%0d", i, stall_count, flush_count, m_sc, m_fc);
      end
      adv();
    end
    reset = 1'b0;
  endtask

  initial begin
    clear_in();
    test_reset();
    test_fwd();
    test_load_use();
    test_load_branch();
    test_alu_branch();
    test_taken_branch();
    test_reset_in_hold();
    test_zero_reg();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Control-side producer for the pipeline's 2:1 and 3:1 operand muxes.
- Generates the forwarding select lines consumed by the ID-stage branch-comparator muxes and the EX-stage ALU-operand muxes.
- Generates the stall, bubble and flush controls for the PC and the IF/ID and ID/EX pipeline registers.
- Contains a small stall FSM and saturating performance counters; sits beside the ID stage of the 5-stage MIPS pipeline.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- id_rs  input  REG_ADDR_W  rs of the instruction in IF/ID.
- id_rt  input  REG_ADDR_W  rt of the instruction in IF/ID.
- id_uses_rt  input  1  the ID instruction reads rt.
- id_is_branch  input  1  the ID instruction is beq/bne.
- id_branch_taken  input  1  ID comparator result; meaningful only when id_is_branch=1.
- ex_rs  input  REG_ADDR_W  rs held in ID/EX.
- ex_rt  input  REG_ADDR_W  rt held in ID/EX.
- ex_regwrite  input  1  ID/EX RegWrite.
- ex_memread  input  1  ID/EX MemRead.
- ex_rd  input  REG_ADDR_W  destination register in ID/EX, after RegDst.
- mem_regwrite  input  1  EX/MEM RegWrite.
- mem_memread  input  1  EX/MEM MemRead.
- mem_rd  input  REG_ADDR_W  destination register in EX/MEM.
- wb_regwrite  input  1  MEM/WB RegWrite.
- wb_rd  input  REG_ADDR_W  destination register in MEM/WB.
- fwd_ex_a  output  2  EX ALU operand A select.
- fwd_ex_b  output  2  EX ALU operand B select.
- fwd_id_a  output  1  branch comparator A select: 0 = register file, 1 = EX/MEM ALU result.
- fwd_id_b  output  1  branch comparator B select, same encoding as fwd_id_a.
- pc_write  output  1  PC enable.
- ifid_write  output  1  IF/ID enable.
- idex_bubble  output  1  zero the ID/EX control bits.
- ifid_flush  output  1  clear IF/ID.
- stall_count  output  CNT_W  number of stall cycles.
- flush_count  output  CNT_W  number of flushes.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port name reset.
- match(r): r != 0 and (r == id_rs or (id_uses_rt and r == id_rt)).
- EX forwarding, operand A (combinational):
  - 2'b10 if mem_regwrite, mem_rd != 0 and mem_rd == ex_rs.
  - else 2'b01 if wb_regwrite, wb_rd != 0 and wb_rd == ex_rs.
  - else 2'b00.
  - EX/MEM wins when both stages match.
- EX forwarding, operand B: same rules using ex_rt.
- ID forwarding: fwd_id_a = mem_regwrite and !mem_memread and mem_rd != 0 and mem_rd == id_rs. fwd_id_b is the same using id_rt, and additionally requires id_uses_rt.
- No WB-to-ID forwarding: the register file is write-before-read.
- Hazard need, n (combinational, evaluated in RUN only):
  - n = 2: ex_memread and match(ex_rd) and id_is_branch.
  - n = 1, any of the following:
    - ex_memread and match(ex_rd) and !id_is_branch.
    - id_is_branch and ex_regwrite and !ex_memread and match(ex_rd).
    - id_is_branch and mem_memread and match(mem_rd).
  - Otherwise n = 0. The maximum applicable value wins.
- Stall FSM, states RUN and HOLD:
  - RUN with n > 0: stall asserted in the same cycle (Mealy). Next state is HOLD if n = 2, else RUN.
  - RUN with n = 0: no stall.
  - HOLD: stall asserted unconditionally for exactly one cycle; hazard inputs are ignored; next state is RUN.
- While stall is asserted: pc_write = 0, ifid_write = 0, idex_bubble = 1.
- ifid_flush = id_is_branch and id_branch_taken and !stall. A flush is never asserted together with a stall.
- Counters (registered):
  - stall_count increments on each clock edge where stall = 1.
  - flush_count increments on each clock edge where ifid_flush = 1.
  - Both saturate at all-ones.
- Reset:
  - While reset = 1: state = RUN, counters = 0, pc_write = 1, ifid_write = 1, idex_bubble = 0, ifid_flush = 0, all fwd_* = 0.
  - Reset asserted in HOLD returns to RUN immediately, with no residual stall after release.
- Register 0 never triggers forwarding or a stall.

Decomposition:
- Shared package:
  - Forwarding constants: FWD_NONE = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - FSM encoding: ST_RUN = 1'b0, ST_HOLD = 1'b1.
  - REG_ADDR_W default.
- Sub-module hazard_fwd_sel: combinational three-way priority comparator producing one 2-bit select.
  - Instantiate twice, once for ex_rs and once for ex_rt.
  - The ID selects are derived from the MEM term of the same logic.

Test Plan:
- ex_regwrite/EX-MEM: mem_regwrite=1, mem_rd=8, wb_regwrite=1, wb_rd=8, ex_rs=8 -> fwd_ex_a=2'b10; with mem_rd=9 -> fwd_ex_a=2'b01.
- Load-use: ex_memread=1, ex_rd=5, id_rs=5, id_is_branch=0 -> one stall cycle (pc_write=0, idex_bubble=1), then RUN; stall_count=1.
- Load then branch: ex_memread=1, ex_rd=5, id_rs=5, id_is_branch=1 -> stall in two consecutive cycles (RUN then HOLD); then fwd_id_a=0 and the branch resolves; stall_count=2.
- ALU then branch: ex_regwrite=1, ex_rd=3, id_rt=3, id_uses_rt=1, id_is_branch=1 -> one stall; next cycle mem_rd=3 gives fwd_id_b=1.
- Taken branch: id_is_branch=1, id_branch_taken=1, no hazard -> ifid_flush=1, flush_count increments; the same inputs with a stall pending -> ifid_flush=0.
- Reset/zero register: reset pulse during HOLD -> RUN, counters 0, pc_write=1; ex_rd=0 with ex_memread=1, id_rs=0 -> no stall.
